day10_line_parser: RTL and testbench



---
 rtl/day10_line_parser_pkg.sv | 28 ++
 rtl/day10_decimal_accum.sv | 46 ++++
 rtl/day10_line_parser.sv | 250 +++++++++++++++++++++++++
 tb/tb_day10_line_parser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/day10_line_parser_pkg.sv
// Shared constants and types for the day-10 line parser.
// Holds the ASCII byte codes, the parser state encoding and a digit classifier.
package day10_pkg;

  localparam logic [7:0] CH_LBRACK = 8'h5B;
  localparam logic [7:0] CH_RBRACK = 8'h5D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;

  typedef enum logic [2:0] {
    IDLE, LIGHTS, GAP, BUTTON, JOLT, EOL, EMIT, SKIP
  } parse_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_ZERO) && (c <= CH_NINE);
  endfunction

endpackage

// File: rtl/day10_decimal_accum.sv
// Saturating decimal accumulator: acc <= acc*10 + digit, pinned at all-ones on overflow.
// Saturation guarantees an oversized index can never wrap into a legal one.
module day10_decimal_accum #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc
);

  localparam logic [ACC_W+3:0] TEN = (ACC_W+4)'(10);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W+3:0] prod_s;

  // next accumulator value; clear wins over a digit
  always_comb begin
    prod_s = ({4'b0000, acc_q} * TEN) + {{ACC_W{1'b0}}, digit};
    if (clear) begin
      acc_d = '0;
    end else if (digit_valid) begin
      if (prod_s > {4'b0000, {ACC_W{1'b1}}}) begin
        acc_d = '1;
      end else begin
        acc_d = prod_s[ACC_W-1:0];
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/day10_line_parser.sv
// Parses one ASCII machine line ([lights] (buttons)... {jolts}\n) into a record
// and hands it out over a valid/ready handshake; malformed lines pulse parse_error.
module day10_line_parser
  import day10_pkg::*;
#(
  parameter int MAX_NUM_LIGHTS    = 10,
  parameter int MAX_NUM_BUTTONS   = 13,
  parameter int MAX_NUM_LIGHTS_W  = MAX_NUM_LIGHTS  <= 1 ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
  parameter int MAX_NUM_BUTTONS_W = MAX_NUM_BUTTONS <= 1 ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [7:0]                                      in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [MAX_NUM_LIGHTS_W-1:0]                     num_lights,
  output logic [MAX_NUM_BUTTONS_W-1:0]                    num_buttons,
  output logic [MAX_NUM_LIGHTS-1:0]                       target_lights_arrangement,
  output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  buttons,
  output logic                                            parse_error
);

  localparam int ACC_W = MAX_NUM_LIGHTS_W + 4;

  parse_state_t state_q, state_d;
  logic [MAX_NUM_LIGHTS_W-1:0]                    num_lights_q, num_lights_d;
  logic [MAX_NUM_BUTTONS_W-1:0]                   num_buttons_q, num_buttons_d;
  logic [MAX_NUM_LIGHTS-1:0]                      target_q, target_d;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons_q, buttons_d;
  logic have_digit_q, have_digit_d;
  logic after_comma_q, after_comma_d;
  logic out_valid_q, out_valid_d;
  logic in_ready_q, in_ready_d;
  logic parse_error_q, parse_error_d;

  logic                      byte_take_s, err_s, or_mask_s, idx_ok_s;
  logic                      acc_clear_s, acc_digit_s;
  logic [ACC_W-1:0]          acc_s;
  logic [MAX_NUM_LIGHTS-1:0] mask_s;

  day10_decimal_accum #(.ACC_W(ACC_W)) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear_s),
    .digit_valid (acc_digit_s),
    .digit       (in_data[3:0]),
    .acc         (acc_s)
  );

  // spaces and carriage returns are swallowed in every state
  assign byte_take_s = in_valid && in_ready_q && (in_data != CH_SP) && (in_data != CH_CR);
  assign idx_ok_s    = (acc_s < {4'b0000, num_lights_q});

  // one-hot mask of the index currently in the accumulator
  always_comb begin
    mask_s = '0;
    for (int k = 0; k < MAX_NUM_LIGHTS; k++) begin
      mask_s[k] = (acc_s == ACC_W'(k));
    end
  end

  // next-state and record update for the accepted byte
  always_comb begin
    state_d       = state_q;
    num_lights_d  = num_lights_q;
    num_buttons_d = num_buttons_q;
    target_d      = target_q;
    buttons_d     = buttons_q;
    have_digit_d  = have_digit_q;
    after_comma_d = after_comma_q;
    err_s         = 1'b0;
    or_mask_s     = 1'b0;
    acc_clear_s   = 1'b0;
    acc_digit_s   = 1'b0;

    if (state_q == EMIT) begin
      if (out_ready) begin
        state_d = IDLE;
      end else begin
        state_d = EMIT;
      end
    end else if (byte_take_s) begin
      case (state_q)
        IDLE: begin
          if (in_data == CH_LBRACK) begin
            num_lights_d  = '0;
            num_buttons_d = '0;
            target_d      = '0;
            buttons_d     = '0;
            state_d       = LIGHTS;
          end else if (in_data == CH_NL) begin
            state_d = IDLE;
          end else begin
            err_s = 1'b1;
          end
        end
        LIGHTS: begin
          if ((in_data == CH_HASH) || (in_data == CH_DOT)) begin
            if (num_lights_q == MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS)) begin
              err_s = 1'b1;
            end else begin
              for (int k = 0; k < MAX_NUM_LIGHTS; k++) begin
                if ((num_lights_q == MAX_NUM_LIGHTS_W'(k)) && (in_data == CH_HASH)) begin
                  target_d[k] = 1'b1;
                end else begin
                  target_d[k] = target_q[k];
                end
              end
              num_lights_d = num_lights_q + MAX_NUM_LIGHTS_W'(1);
            end
          end else if (in_data == CH_RBRACK) begin
            state_d = GAP;
          end else begin
            err_s = 1'b1;
          end
        end
        GAP: begin
          if (in_data == CH_LPAREN) begin
            if (num_buttons_q == MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS)) begin
              err_s = 1'b1;
            end else begin
              acc_clear_s   = 1'b1;
              have_digit_d  = 1'b0;
              after_comma_d = 1'b0;
              state_d       = BUTTON;
            end
          end else if (in_data == CH_LBRACE) begin
            state_d = JOLT;
          end else begin
            err_s = 1'b1;
          end
        end
        BUTTON: begin
          if (is_digit(in_data)) begin
            acc_digit_s  = 1'b1;
            have_digit_d = 1'b1;
          end else if (in_data == CH_COMMA) begin
            if (!have_digit_q || !idx_ok_s) begin
              err_s = 1'b1;
            end else begin
              or_mask_s     = 1'b1;
              acc_clear_s   = 1'b1;
              have_digit_d  = 1'b0;
              after_comma_d = 1'b1;
            end
          end else if (in_data == CH_RPAREN) begin
            // "()" is a legal empty button, but "(1,)" is not
            if (have_digit_q ? !idx_ok_s : after_comma_q) begin
              err_s = 1'b1;
            end else begin
              or_mask_s     = have_digit_q;
              num_buttons_d = num_buttons_q + MAX_NUM_BUTTONS_W'(1);
              state_d       = GAP;
            end
          end else begin
            err_s = 1'b1;
          end
        end
        JOLT: begin
          if (in_data == CH_RBRACE) begin
            state_d = EOL;
          end else if (in_data == CH_NL) begin
            err_s = 1'b1;
          end else begin
            state_d = JOLT;
          end
        end
        EOL: begin
          if (in_data == CH_NL) begin
            state_d = EMIT;
          end else begin
            err_s = 1'b1;
          end
        end
        SKIP: begin
          if (in_data == CH_NL) begin
            state_d = IDLE;
          end else begin
            state_d = SKIP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (or_mask_s) begin
      for (int j = 0; j < MAX_NUM_BUTTONS; j++) begin
        if (num_buttons_q == MAX_NUM_BUTTONS_W'(j)) begin
          buttons_d[j] = buttons_q[j] | mask_s;
        end else begin
          buttons_d[j] = buttons_q[j];
        end
      end
    end else begin
      buttons_d = buttons_d;
    end

    if (err_s) begin
      state_d = (in_data == CH_NL) ? IDLE : SKIP;
    end else begin
      state_d = state_d;
    end

    out_valid_d   = (state_d == EMIT);
    in_ready_d    = (state_d != EMIT);
    parse_error_d = err_s;
  end

  // parser state and registered record/handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      num_lights_q  <= '0;
      num_buttons_q <= '0;
      target_q      <= '0;
      buttons_q     <= '0;
      have_digit_q  <= 1'b0;
      after_comma_q <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      parse_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_lights_q  <= num_lights_d;
      num_buttons_q <= num_buttons_d;
      target_q      <= target_d;
      buttons_q     <= buttons_d;
      have_digit_q  <= have_digit_d;
      after_comma_q <= after_comma_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      parse_error_q <= parse_error_d;
    end
  end

  assign in_ready                  = in_ready_q;
  assign out_valid                 = out_valid_q;
  assign parse_error               = parse_error_q;
  assign num_lights                = num_lights_q;
  assign num_buttons               = num_buttons_q;
  assign target_lights_arrangement = target_q;
  assign buttons                   = buttons_q;

endmodule

// File: tb/tb_day10_line_parser.sv
// Directed bench for day10_line_parser: a default-size instance (a) and a
// 12-light / 2-button instance (b), checked against hand-computed records.
module tb_day10_line_parser;

  logic clk = 1'b0;
  logic rst;

  logic              iv_a, ir_a, ov_a, or_a, pe_a;
  logic [7:0]        id_a;
  logic [3:0]        nl_a, nb_a;
  logic [9:0]        tg_a;
  logic [12:0][9:0]  bt_a;

  logic              iv_b, ir_b, ov_b, or_b, pe_b;
  logic [7:0]        id_b;
  logic [3:0]        nl_b;
  logic [1:0]        nb_b;
  logic [11:0]       tg_b;
  logic [1:0][11:0]  bt_b;

  int checks = 0;
  int errors = 0;
  int pe_cnt_a = 0, pe_cnt_b = 0, rec_cnt_a = 0, rec_cnt_b = 0;
  int pe0;

  day10_line_parser dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .num_lights(nl_a), .num_buttons(nb_a),
    .target_lights_arrangement(tg_a), .buttons(bt_a), .parse_error(pe_a)
  );

  day10_line_parser #(.MAX_NUM_LIGHTS(12), .MAX_NUM_BUTTONS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .num_lights(nl_b), .num_buttons(nb_b),
    .target_lights_arrangement(tg_b), .buttons(bt_b), .parse_error(pe_b)
  );

  always #5 clk = ~clk;

  // count error pulses and accepted records on the quiet edge
  always @(negedge clk) begin
    if (pe_a) pe_cnt_a++;
    if (pe_b) pe_cnt_b++;
    if (ov_a && or_a) rec_cnt_a++;
    if (ov_b && or_b) rec_cnt_b++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n;
    n = 0;
    if (sel) begin iv_b = 1'b1; id_b = b; end
    else     begin iv_a = 1'b1; id_a = b; end
    while (!(sel ? ir_b : ir_a) && (n < 50)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("in_ready_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    if (sel) iv_b = 1'b0;
    else     iv_a = 1'b0;
  endtask

  task automatic send_line(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
  endtask

  task automatic wait_record(input bit sel);
    int n;
    n = 0;
    while (!(sel ? ov_b : ov_a) && (n < 50)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("record_timeout", 64'(n), 64'd0);
  endtask

  task automatic take(input bit sel);
    if (sel) or_b = 1'b1;
    else     or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0;
    or_b = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    iv_a = 1'b0; id_a = 8'h00; or_a = 1'b0;
    iv_b = 1'b0; id_b = 8'h00; or_b = 1'b0;
    idle_cycles(3);
    rst = 1'b0;

    check_eq("rst_flags_a", {ov_a, ir_a, pe_a}, {1'b0, 1'b1, 1'b0});
    check_eq("rst_counts_a", {nl_a, nb_a, tg_a}, 64'd0);
    check_eq("rst_buttons_a", 64'(bt_a == '0), 64'd1);
    check_eq("rst_flags_b", {ov_b, ir_b, pe_b}, {1'b0, 1'b1, 1'b0});

    // puzzle example; out_valid must rise right after the newline
    send_line(1'b0, "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}");
    check_eq("ov_before_nl", 64'(ov_a), 64'd0);
    send_byte(1'b0, 8'h0A);
    check_eq("ov_after_nl", 64'(ov_a), 64'd1);
    check_eq("ex_num_lights", 64'(nl_a), 64'd4);
    check_eq("ex_target", 64'(tg_a), 64'h6);
    check_eq("ex_num_buttons", 64'(nb_a), 64'd6);
    check_eq("ex_b0", 64'(bt_a[0]), 64'h8);
    check_eq("ex_b1", 64'(bt_a[1]), 64'hA);
    check_eq("ex_b2", 64'(bt_a[2]), 64'h4);
    check_eq("ex_b3", 64'(bt_a[3]), 64'hC);
    check_eq("ex_b4", 64'(bt_a[4]), 64'h5);
    check_eq("ex_b5", 64'(bt_a[5]), 64'h3);
    check_eq("ex_b6", 64'(bt_a[6]), 64'h0);

    // backpressure with the next line's first byte pending
    iv_a = 1'b1;
    id_a = 8'h5B;
    for (int c = 0; c < 10; c++) begin
      check_eq("bp_stall", {ir_a, ov_a, nl_a, tg_a, nb_a, bt_a[1]},
               {1'b0, 1'b1, 4'd4, 10'h6, 4'd6, 10'hA});
      idle_cycles(1);
    end
    take(1'b0);
    check_eq("bp_release", {ov_a, ir_a}, {1'b0, 1'b1});
    send_line(1'b0, "[..#] (0,2) () {7}\n");
    wait_record(1'b0);
    check_eq("r2_fields", {nl_a, tg_a, nb_a}, {4'd3, 10'h4, 4'd2});
    check_eq("r2_b0", 64'(bt_a[0]), 64'h5);
    check_eq("r2_b1_empty", 64'(bt_a[1]), 64'h0);
    take(1'b0);
    check_eq("rec_count_2", 64'(rec_cnt_a), 64'd2);

    // out-of-range index rejects the line, next line is fine
    pe0 = pe_cnt_a;
    send_line(1'b0, "[.#] (2");
    send_byte(1'b0, 8'h29);
    check_eq("pe_pulse", 64'(pe_a), 64'd1);
    send_line(1'b0, " {1}\n");
    check_eq("pe_one_cycle", 64'(pe_a), 64'd0);
    idle_cycles(3);
    check_eq("pe_count", 64'(pe_cnt_a - pe0), 64'd1);
    check_eq("err_no_record", {ov_a, 8'(rec_cnt_a)}, {1'b0, 8'd2});
    send_line(1'b0, "[#] (0) {1}\n");
    wait_record(1'b0);
    check_eq("r3_fields", {nl_a, tg_a, nb_a, bt_a[0]}, {4'd1, 10'h1, 4'd1, 10'h1});
    take(1'b0);
    check_eq("rec_count_3", 64'(rec_cnt_a), 64'd3);

    // reset in the middle of a button list
    pe0 = pe_cnt_a;
    send_line(1'b0, "[##] (1");
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    check_eq("mid_rst_flags", {ov_a, ir_a, pe_a}, {1'b0, 1'b1, 1'b0});
    check_eq("mid_rst_counts", {nl_a, nb_a, tg_a}, 64'd0);
    check_eq("mid_rst_buttons", 64'(bt_a == '0), 64'd1);
    idle_cycles(2);
    check_eq("mid_rst_no_pe", 64'(pe_cnt_a - pe0), 64'd0);
    send_line(1'b0, "[#.] (0) {}\n");
    wait_record(1'b0);
    check_eq("r4_fields", {nl_a, tg_a, nb_a, bt_a[0]}, {4'd2, 10'h1, 4'd1, 10'h1});
    take(1'b0);

    // small instance: too many buttons, then a 12-light line after a blank line
    pe0 = pe_cnt_b;
    send_line(1'b1, "[##] (0) (1) (0,1) {}\n");
    idle_cycles(3);
    check_eq("b_pe_count", 64'(pe_cnt_b - pe0), 64'd1);
    check_eq("b_no_record", {ov_b, 8'(rec_cnt_b)}, {1'b0, 8'd0});
    send_line(1'b1, " \r\n[............] (10,11) {}\r\n");
    wait_record(1'b1);
    check_eq("b12_fields", {nl_b, tg_b, nb_b}, {4'd12, 12'h000, 2'd1});
    check_eq("b12_b0", 64'(bt_b[0]), 64'hC00);
    check_eq("b12_b1", 64'(bt_b[1]), 64'h000);
    take(1'b1);
    check_eq("b_rec_count", 64'(rec_cnt_b), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
